// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
               alusrca, alusrcb, alu_op, imm_src, illegal, instr_done, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
               alusrca, alusrcb, alu_op, imm_src, illegal, instr_done, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RISC-V core (lw, sw, R, I, beq, jal, lui).
// Define MC_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 7'b0110111;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;
    localparam logic [SEL_W-1:0] RES_IMM    = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I  = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S  = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B  = 2'b10;
    localparam logic [SEL_W-1:0] IMM_JU = 2'b11;

    state_e state_q;
    state_e state_d;

    logic             mem_done_c;
    logic             pcupdate_c;
    logic             branch_c;
    logic             pcwrite_c;
    logic             adrsrc_c;
    logic             memwrite_c;
    logic             irwrite_c;
    logic             regwrite_c;
    logic [SEL_W-1:0] resultsrc_c;
    logic [SEL_W-1:0] alusrca_c;
    logic [SEL_W-1:0] alusrcb_c;
    logic [SEL_W-1:0] alu_op_c;
    logic [SEL_W-1:0] imm_src_c;
    logic             illegal_c;
    logic             instr_done_c;

    // Memory-access completion: slow memory gates the stalling states.
`ifdef MC_MEM_WAIT_EN
    assign mem_done_c = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_done_c       = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs; write strobes are squashed during reset.
    always_comb begin
        state_d      = state_q;
        pcupdate_c   = 1'b0;
        branch_c     = 1'b0;
        adrsrc_c     = 1'b0;
        memwrite_c   = 1'b0;
        irwrite_c    = 1'b0;
        regwrite_c   = 1'b0;
        resultsrc_c  = RES_ALUOUT;
        alusrca_c    = SRCA_PC;
        alusrcb_c    = SRCB_RD2;
        alu_op_c     = ALUOP_ADD;
        illegal_c    = 1'b0;
        instr_done_c = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                adrsrc_c    = 1'b0;
                irwrite_c   = mem_done_c;
                alusrca_c   = SRCA_PC;
                alusrcb_c   = SRCB_FOUR;
                alu_op_c    = ALUOP_ADD;
                resultsrc_c = RES_ALURES;
                pcupdate_c  = mem_done_c;
                if (mem_done_c) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC + imm is formed here so beq/jal have their target ready.
                alusrca_c = SRCA_OLDPC;
                alusrcb_c = SRCB_IMM;
                alu_op_c  = ALUOP_ADD;
                unique case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_c    = 1'b1;
                        instr_done_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c = SRCA_RD1;
                alusrcb_c = SRCB_IMM;
                alu_op_c  = ALUOP_ADD;
                state_d   = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc_c    = 1'b1;
                resultsrc_c = RES_ALUOUT;
                if (mem_done_c) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultsrc_c  = RES_DATA;
                regwrite_c   = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc_c     = 1'b1;
                memwrite_c   = 1'b1;
                instr_done_c = mem_done_c;
                if (mem_done_c) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alusrca_c = SRCA_RD1;
                alusrcb_c = SRCB_RD2;
                alu_op_c  = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca_c = SRCA_RD1;
                alusrcb_c = SRCB_IMM;
                alu_op_c  = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                resultsrc_c  = RES_ALUOUT;
                regwrite_c   = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                alusrca_c    = SRCA_RD1;
                alusrcb_c    = SRCB_RD2;
                alu_op_c     = ALUOP_SUB;
                resultsrc_c  = RES_ALUOUT;
                branch_c     = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd.
                alusrca_c   = SRCA_OLDPC;
                alusrcb_c   = SRCB_FOUR;
                alu_op_c    = ALUOP_ADD;
                resultsrc_c = RES_ALUOUT;
                pcupdate_c  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_LUI: begin
                resultsrc_c  = RES_IMM;
                regwrite_c   = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        pcwrite_c = pcupdate_c | (branch_c & bus.zero);

        if (reset) begin
            pcwrite_c    = 1'b0;
            irwrite_c    = 1'b0;
            regwrite_c   = 1'b0;
            memwrite_c   = 1'b0;
            illegal_c    = 1'b0;
            instr_done_c = 1'b0;
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src_c = IMM_I;
        unique case (bus.opcode)
            OP_LW, OP_ITYPE: imm_src_c = IMM_I;
            OP_SW:           imm_src_c = IMM_S;
            OP_BEQ:          imm_src_c = IMM_B;
            OP_JAL, OP_LUI:  imm_src_c = IMM_JU;
            default:         imm_src_c = IMM_I;
        endcase
    end

    assign bus.pcwrite    = pcwrite_c;
    assign bus.adrsrc     = adrsrc_c;
    assign bus.memwrite   = memwrite_c;
    assign bus.irwrite    = irwrite_c;
    assign bus.regwrite   = regwrite_c;
    assign bus.resultsrc  = resultsrc_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.imm_src    = imm_src_c;
    assign bus.illegal    = illegal_c;
    assign bus.instr_done = instr_done_c;
    assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors
// are queued by the driver and checked by an independent negedge monitor.
module tb_multicycle_controller;
    logic clk;
    logic reset;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        logic [20:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector {state,pcwrite,adrsrc,memwrite,irwrite,regwrite,resultsrc,
    // alusrca,alusrcb,alu_op,imm_src,illegal,instr_done} from the state table.
    function automatic logic [20:0] exp_vec(input logic [3:0] st);
        logic       pcw, adr, mw, irw, rw, ill, done, gate;
        logic [1:0] rs, sa, sb, aop, imm;
        logic [6:0] op;
        op   = bus.opcode;
        pcw  = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; done = 0;
        rs   = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
`ifdef MC_MEM_WAIT_EN
        gate = bus.mem_ready;
`else
        gate = 1'b1;
`endif
        case (st)
            4'd0:  begin irw = gate; pcw = gate; sb = 2'b10; rs = 2'b10; end
            4'd1:  begin
                sa = 2'b01; sb = 2'b01;
                if (!(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI})) begin
                    ill = 1; done = 1;
                end
            end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  begin adr = 1; end
            4'd4:  begin rs = 2'b01; rw = 1; done = 1; end
            4'd5:  begin adr = 1; mw = 1; done = gate; end
            4'd6:  begin sa = 2'b10; aop = 2'b10; end
            4'd7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            4'd8:  begin rw = 1; done = 1; end
            4'd9:  begin sa = 2'b10; aop = 2'b01; pcw = bus.zero; done = 1; end
            4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            4'd11: begin rs = 2'b11; rw = 1; done = 1; end
            default: ;
        endcase
        case (op)
            OP_SW:          imm = 2'b01;
            OP_BEQ:         imm = 2'b10;
            OP_JAL, OP_LUI: imm = 2'b11;
            default:        imm = 2'b00;
        endcase
        if (reset) begin
            pcw = 0; irw = 0; rw = 0; mw = 0; ill = 0; done = 0;
        end
        return {st, pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm, ill, done};
    endfunction

    // Queue the expectation for this cycle, then advance to just after the next edge.
    task automatic step(input logic [3:0] st, input string name);
        exp_t e;
        e.v    = exp_vec(st);
        e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // seq holds the state sequence, first state in the low nibble; zero is
    // inverted before the last cycle so only the final-cycle sample may matter.
    task automatic run_instr(input logic [6:0] op, input logic zf,
                             input logic [23:0] seq, input int n, input string name);
        bus.opcode = op;
        for (int i = 0; i < n; i++) begin
            bus.zero = (i == n - 1) ? zf : ~zf;
            step(seq[i*4 +: 4], $sformatf("%s_c%0d", name, i + 1));
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [20:0] act;
            e   = q.pop_front();
            act = {bus.state, bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite,
                   bus.regwrite, bus.resultsrc, bus.alusrca, bus.alusrcb, bus.alu_op,
                   bus.imm_src, bus.illegal, bus.instr_done};
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.opcode    = 7'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(4'd0, "reset_hold");
        reset = 1'b0;

        run_instr(OP_LW,  1'b0, 24'h043210, 5, "lw");
        run_instr(OP_SW,  1'b0, 24'h005210, 4, "sw");
        run_instr(OP_R,   1'b0, 24'h008610, 4, "rtype");
        run_instr(OP_I,   1'b0, 24'h008710, 4, "itype");
        run_instr(OP_BEQ, 1'b1, 24'h000910, 3, "beq_taken");
        run_instr(OP_BEQ, 1'b0, 24'h000910, 3, "beq_not_taken");
        run_instr(OP_JAL, 1'b0, 24'h008A10, 4, "jal");
        run_instr(OP_LUI, 1'b0, 24'h000B10, 3, "lui");
        run_instr(OP_BAD, 1'b0, 24'h000010, 2, "illegal");

        // Abandon a load in MEMREAD with an asynchronous reset.
        run_instr(OP_LW, 1'b0, 24'h000210, 3, "lw_pre_reset");
        reset = 1'b1;
        step(4'd0, "reset_in_memread");
        step(4'd0, "reset_in_memread_hold");
        reset = 1'b0;
        run_instr(OP_LW, 1'b0, 24'h043210, 5, "lw_after_reset");

`ifdef MC_MEM_WAIT_EN
        bus.opcode    = OP_R;
        bus.mem_ready = 1'b0;
        repeat (3) step(4'd0, "fetch_wait");
        bus.mem_ready = 1'b1;
        run_instr(OP_R, 1'b0, 24'h008610, 4, "rtype_after_wait");
        run_instr(OP_SW, 1'b0, 24'h000210, 3, "sw_pre_wait");
        bus.mem_ready = 1'b0;
        repeat (2) step(4'd5, "memwrite_wait");
        bus.mem_ready = 1'b1;
        step(4'd5, "memwrite_done");
`else
        bus.mem_ready = 1'b0;
        run_instr(OP_SW, 1'b0, 24'h005210, 4, "sw_memready_low");
        run_instr(OP_LW, 1'b0, 24'h043210, 5, "lw_memready_low");
        bus.mem_ready = 1'b1;
`endif
        run_instr(OP_LUI, 1'b0, 24'h000B10, 3, "lui_final");

        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM for the multi-cycle RISC-V core: sequences one shared ALU, one unified instruction/data memory and the register file over several cycles per instruction. Takes the opcode from the instruction register and the ALU `zero` flag, and drives every datapath enable and mux select. Supports lw, sw, R-type, I-type ALU, beq, jal and lui. An optional memory-wait handshake lets it stall on slow memory.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; state returns to FETCH
- opcode  input  7  instruction[6:0] from instruction register
- zero  input  1  ALU zero flag, same cycle
- mem_ready  input  1  memory access completes this cycle (only with MC_MEM_WAIT_EN)
- pcwrite  output  1  PC register enable
- adrsrc  output  1  memory address: 0=PC, 1=ALUOut
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register / OldPC enable
- regwrite  output  1  register file write enable
- resultsrc  output  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- alusrca  output  2  00 PC, 01 OldPC, 10 RD1
- alusrcb  output  2  00 RD2, 01 ImmExt, 10 constant 4
- alu_op  output  2  00 add, 01 subtract, 10 funct-decoded
- imm_src  output  2  00 I, 01 S, 10 B, 11 J/U
- illegal  output  1  one-cycle pulse, unsupported opcode in DECODE
- instr_done  output  1  one-cycle pulse, last cycle of an instruction
- state  output  4  current state encoding, for debug/verification

## Operation
- States, encodings 0-11: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, LUI.
- Unlisted outputs are 0 in each state.
- FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, alu_op=00, resultsrc=10, pcupdate=1. Next state DECODE.
- DECODE: alusrca=01, alusrcb=01, alu_op=00. This computes the branch/jump target.
  - lw or sw -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other opcode -> FETCH with illegal=1 and instr_done=1
- MEMADR: alusrca=10, alusrcb=01, alu_op=00. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adrsrc=1, resultsrc=00. Next state MEMWB.
- MEMWB: resultsrc=01, regwrite=1, instr_done=1. Next state FETCH.
- MEMWRITE: adrsrc=1, memwrite=1, instr_done=1. Next state FETCH.
- EXECUTER: alusrca=10, alusrcb=00, alu_op=10. Next state ALUWB.
- EXECUTEI: alusrca=10, alusrcb=01, alu_op=10. Next state ALUWB.
- ALUWB: resultsrc=00, regwrite=1, instr_done=1. Next state FETCH.
- BEQ: alusrca=10, alusrcb=00, alu_op=01, resultsrc=00, branch=1, instr_done=1. Next state FETCH.
- JAL: alusrca=01, alusrcb=10, alu_op=00, resultsrc=00, pcupdate=1. Next state ALUWB.
- LUI: resultsrc=11, regwrite=1, instr_done=1. Next state FETCH.
- pcwrite = pcupdate | (branch & zero).
- imm_src is combinational from opcode in every state: lw/I-type 00, sw 01, beq 10, jal/lui 11, others 00.

## Timing
- Next state is registered on the rising clk edge. All outputs are combinational from state, opcode, zero and mem_ready, with no output registers.
- Reset asserted: state=FETCH immediately, independent of clk. pcwrite, irwrite, regwrite, memwrite, illegal and instr_done are forced 0 while reset is high. The other outputs show FETCH values.
- Reset asserted mid-instruction abandons the instruction. No write enable asserts in the cycle reset is high.
- Cycles per instruction with no wait:
  - lw 5
  - sw, R-type, I-type, jal 4
  - beq, lui 3
  - illegal 2
- beq taken/not-taken decision uses zero sampled in the BEQ cycle only.

## Configuration
- MC_MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold state until mem_ready=1.
  - In FETCH, irwrite and pcwrite are asserted only in the cycle where mem_ready=1.
  - In MEMWRITE, memwrite stays high every waiting cycle; instr_done is asserted only on the cycle with mem_ready=1.
  - adrsrc and the other selects are held stable while waiting.
- MC_MEM_WAIT_EN undefined: mem_ready is ignored and every state lasts exactly one cycle.

## Test plan
- Reset: assert reset mid-MEMREAD -> state=0 asynchronously, all write enables 0. Release -> FETCH, with irwrite=1 and pcwrite=1 on the first cycle.
- lw (0000011) -> states 0,1,2,3,4. regwrite=1 with resultsrc=01 in cycle 5 only; instr_done pulses once.
- sw (0100011) -> states 0,1,2,5. memwrite=1, adrsrc=1 in cycle 4; imm_src=01 throughout.
- beq: once with zero=1 and once with zero=0. pcwrite=1 in the BEQ cycle only when zero=1; 3 cycles each.
- jal (1101111) -> states 0,1,10,8. pcwrite=1 in JAL with alusrca=01, alusrcb=10; regwrite in ALUWB. lui (0110111) -> states 0,1,11 with resultsrc=11.
- Opcode 1111111 -> illegal=1 in DECODE, back to FETCH, no regwrite/memwrite. With MC_MEM_WAIT_EN and mem_ready low for 3 cycles in FETCH -> state stays 0 and irwrite stays 0 until mem_ready=1.
